rom_read_arbiter: RTL

- Shares one combinational rom_module (256 x 32-bit, word-indexed by address[31:2]) between two independent read requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; one read is in flight at a time.
- Drives the ROM address, registers the returned word, and reports out-of-range accesses.

---
 rtl/rom_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 24 ++
 rtl/rom_read_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the ROM read arbiter.
// The FSM state encoding and ROM geometry are defined here.
package rom_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned ROM_DEPTH  = 256;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. This block is purely combinational.
// When both requests are set, the pointer picks the winner.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_id_o = 1'b0;
        gnt_o    = 2'b00;
        unique case (req_i)
            2'b01: gnt_id_o = 1'b0;
            2'b10: gnt_id_o = 1'b1;
            2'b11: gnt_id_o = ptr_i;
            default: gnt_id_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational ROM between two valid/ready requesters.
// Only one read is in flight at a time, and the requesters are served round-robin.
module rom_read_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    output logic              req0_ready_o,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic              rsp0_err_o,
    input  logic              rsp0_ready_i,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    output logic              req1_ready_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic              rsp1_err_o,
    input  logic              rsp1_ready_i,
    output logic [ADDR_W-1:0] rom_address_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    // Every address bit at or above this position is outside the ROM.
    localparam int unsigned RangeLsb = $clog2(DEPTH) + WORD_SHIFT;
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(2 ** WORD_SHIFT - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic [1:0]        arb_gnt;
    logic              arb_gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] rd_word;
    logic              rsp_ready;

    rr_arb2 u_arb (
        .req_i    ({req1_valid_i, req0_valid_i}),
        .ptr_i    (ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_gnt_id)
    );

    assign sel_addr  = arb_gnt_id ? req1_addr_i : req0_addr_i;
    assign rd_word   = oor_q ? '0 : rom_data_i;
    assign rsp_ready = gnt_id_q ? rsp1_ready_i : rsp0_ready_i;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        addr_d   = addr_q;
        oor_d    = oor_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        unique case (state_q)
            StIdle: begin
                if (arb_gnt != 2'b00) begin
                    gnt_id_d = arb_gnt_id;
                    addr_d   = sel_addr & AlignMask;
                    oor_d    = |sel_addr[ADDR_W-1:RangeLsb];
                    state_d  = StRead;
                end
            end
            StRead: begin
                if (gnt_id_q) begin
                    data1_d = rd_word;
                    err1_d  = oor_q;
                end else begin
                    data0_d = rd_word;
                    err0_d  = oor_q;
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    ptr_d   = ~gnt_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            gnt_id_q <= 1'b0;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            addr_q   <= addr_d;
            oor_q    <= oor_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    assign req0_ready_o  = (state_q == StIdle) && arb_gnt[0];
    assign req1_ready_o  = (state_q == StIdle) && arb_gnt[1];
    assign rsp0_valid_o  = (state_q == StResp) && !gnt_id_q;
    assign rsp1_valid_o  = (state_q == StResp) && gnt_id_q;
    assign rsp0_data_o   = data0_q;
    assign rsp1_data_o   = data1_q;
    assign rsp0_err_o    = err0_q;
    assign rsp1_err_o    = err1_q;
    assign rom_address_o = addr_q;

endmodule
